mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbiter and sequencer for the single-port unified memory shared by instruction fetch and the execute stage's load/store path. It grants one requester at a time and drives the memory port for the configured read latency. It returns data with a one-cycle valid pulse and generates the pipeline stall that freezes fetch/decode while a data access is pending. It sits between the fetch stage, the execute/memory stage and the memory macro.

## Interface

Parameters:

- `MEM_LAT`, default 2: memory read latency in cycles from `mem_en_o` to valid `mem_rdata_i`; legal range 1..8.
- `MAX_DATA_RUN`, default 4: consecutive data grants allowed while fetch waits. Used only with the fetch guard enabled.

Ports:

- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk_i` input 1: clock.
  - `rst_i` input 1: synchronous active-high reset.
- Fetch requester:
  - `if_req_i` input 1: fetch request.
  - `if_addr_i` input 32: fetch address.
  - `if_gnt_o` output 1: fetch granted; one-cycle pulse.
  - `if_valid_o` output 1: fetch data valid; one-cycle pulse.
  - `if_rdata_o` output 32: fetch read data.
- Data requester:
  - `d_req_i` input 1: data request.
  - `d_we_i` input 1: 1 = store, 0 = load.
  - `d_addr_i` input 32: data address.
  - `d_wdata_i` input 32: store data.
  - `d_gnt_o` output 1: data granted; one-cycle pulse.
  - `d_valid_o` output 1: load data valid or store complete; one-cycle pulse.
  - `d_rdata_o` output 32: load data.
- Pipeline:
  - `stall_o` output 1: pipeline stall to fetch/decode.
- Memory port:
  - `mem_en_o` output 1: memory access enable.
  - `mem_we_o` output 1: memory write enable.
  - `mem_addr_o` output 32: memory address.
  - `mem_wdata_o` output 32: memory write data.
  - `mem_rdata_i` input 32: memory read data.

## Operation

- States: `ARB_IDLE`, `ARB_ISSUE`, `ARB_WAIT`, `ARB_RESP`.
- `ARB_IDLE`:
  - Arbitrates on the current-cycle requests.
  - Winner's address, write data, write enable and owner are registered; next state is `ARB_ISSUE`.
  - With no request, the state stays `ARB_IDLE`.
- Priority: data beats fetch when both request in the same cycle (strict, unless the fetch guard is enabled).
- `ARB_ISSUE` (one cycle):
  - `mem_en_o`=1; `mem_we_o`, `mem_addr_o`, `mem_wdata_o` come from the latched request.
  - Owner's `*_gnt_o`=1. The requester may change or drop its request after seeing the grant.
- `ARB_WAIT` lasts exactly `MEM_LAT` cycles, counted by a latency counter of width $clog2(MEM_LAT+1).
  - On the last `ARB_WAIT` cycle, a load samples `mem_rdata_i` into the owner's rdata register.
  - A store samples nothing.
- `ARB_RESP` (one cycle):
  - Owner's `*_valid_o`=1; next state is `ARB_IDLE`.
  - `*_rdata_o` holds its value until the next load by the same owner.
- `stall_o` = (`d_req_i` OR data transaction in flight) AND NOT `d_valid_o`. It is combinational from `d_req_i` and registered state.
- Requester rules:
  - Request, address and write data are held stable until grant.
  - A request dropped before the arbitration edge is never served.
  - Fetch requests carry no write; `mem_we_o` for a fetch is always 0.
- Outputs `mem_*`, `*_gnt_o` and `*_valid_o` are 0 in every state not listed above.

## Timing

- Reset value of every output is 0. The rdata registers clear to 0; the state resets to `ARB_IDLE` and the counters to 0.
- Reset mid-transaction aborts it: no valid pulse is issued, and the next cycle is `ARB_IDLE`.
- Request in cycle t (state `ARB_IDLE`):
  - Grant and `mem_en_o` in t+1.
  - Data sampled at the end of t+1+`MEM_LAT`.
  - Valid pulse in t+2+`MEM_LAT`.
  - Next arbitration in t+3+`MEM_LAT`.
- Throughput: one access per `MEM_LAT`+3 cycles.
- Only one transaction is outstanding at a time. Requests arriving outside `ARB_IDLE` wait.
- Simultaneous `if_req_i` and `d_req_i` in `ARB_IDLE`: data is granted and fetch waits, with `if_gnt_o`=0.

## Configuration

- `ARB_FETCH_GUARD_EN` defined:
  - A data-run counter increments on each data grant made while `if_req_i`=1.
  - When the count equals `MAX_DATA_RUN` and both request, fetch is granted instead.
  - The counter clears on any fetch grant, and whenever `if_req_i`=0 at arbitration.
- Undefined: strict data priority; the counter logic is absent.

## Structure

- Package `arb_pkg`:
  - `arb_state_t` (the four states).
  - `arb_owner_t` {`OWN_FETCH`, `OWN_DATA`}.
  - Constant `ARB_MAX_LAT` = 8.
- Single module; the latency and run counters are inline. No sub-module.

## Test plan

- Lone load with `MEM_LAT`=2: `d_req_i` at cycle 0, `d_addr_i`=0x100, memory returns 0xDEADBEEF. Required response:
  - `d_gnt_o` and `mem_en_o` at cycle 1 with `mem_addr_o`=0x100.
  - `d_valid_o` at cycle 4 with `d_rdata_o`=0xDEADBEEF.
  - `stall_o`=1 in cycles 0..3 and 0 in cycle 4.
- Store: `d_we_i`=1, address 0x20, data 0x12345678. Required response:
  - `mem_we_o`=1 with those values for exactly one cycle.
  - `d_valid_o` at cycle 4.
  - `d_rdata_o` unchanged.
- Simultaneous requests: both at cycle 0. Required response:
  - Data is served, `if_gnt_o` at cycle 6 and `if_valid_o` at cycle 9.
  - `stall_o`=1 only through cycle 3.
- Fetch guard with macro defined, `MAX_DATA_RUN`=4, both requests held high: grants follow the pattern D,D,D,D,F,D,… Without the macro, fetch is never granted while data is held.
- Reset at cycle 2 of a load: no `d_valid_o`, all outputs 0 in cycle 3. A new request at cycle 3 is granted at cycle 4.
- `MEM_LAT`=1 and `MEM_LAT`=8 lone fetches: `if_valid_o` at cycle 3 and cycle 10 respectively.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, owner tags
// and the maximum supported read latency.
package arb_pkg;
  localparam int ARB_MAX_LAT = 8;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_RESP
  } arb_state_t;

  typedef enum logic {
    OWN_FETCH,
    OWN_DATA
  } arb_owner_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data, stall and memory-port signals of the arbiter, bundled.
// The slave view is the arbiter; the master view is the surrounding pipeline and memory.
interface mem_port_arbiter_if;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_valid_o;
  logic [31:0] if_rdata_o;

  logic        d_req_i;
  logic        d_we_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic        d_gnt_o;
  logic        d_valid_o;
  logic [31:0] d_rdata_o;

  logic        stall_o;

  logic        mem_en_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_rdata_i,
    output if_gnt_o, if_valid_o, if_rdata_o, d_gnt_o, d_valid_o, d_rdata_o,
           stall_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_rdata_i,
    input  if_gnt_o, if_valid_o, if_rdata_o, d_gnt_o, d_valid_o, d_rdata_o,
           stall_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter between fetch and load/store on one memory port.
// Define ARB_FETCH_GUARD_EN to let fetch win after MAX_DATA_RUN back-to-back data grants.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int MEM_LAT      = 2,
  parameter int MAX_DATA_RUN = 4
) (
  input logic               clk_i,
  input logic               rst_i,
  mem_port_arbiter_if.slave bus
);

  localparam int LAT_W = $clog2(MEM_LAT + 1);

  if (MEM_LAT < 1 || MEM_LAT > ARB_MAX_LAT || MAX_DATA_RUN < 1) begin : g_cfg_err
    $error("mem_port_arbiter: MEM_LAT or MAX_DATA_RUN out of range");
  end

  arb_state_t       state_q, state_d;
  arb_owner_t       owner_q, owner_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      if_rdata_q, if_rdata_d;
  logic [31:0]      d_rdata_q, d_rdata_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic             take_data;
  logic             d_valid;

`ifdef ARB_FETCH_GUARD_EN
  localparam int RUN_W = $clog2(MAX_DATA_RUN + 1);
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
`endif

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    we_d           = we_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    if_rdata_d     = if_rdata_q;
    d_rdata_d      = d_rdata_q;
    lat_cnt_d      = lat_cnt_q;
    take_data      = 1'b0;
    d_valid        = 1'b0;
    bus.if_gnt_o   = 1'b0;
    bus.if_valid_o = 1'b0;
    bus.d_gnt_o    = 1'b0;
    bus.mem_en_o   = 1'b0;
    bus.mem_we_o   = 1'b0;
    bus.mem_addr_o = '0;
    bus.mem_wdata_o = '0;
`ifdef ARB_FETCH_GUARD_EN
    run_cnt_d      = run_cnt_q;
`endif

    case (state_q)
      ARB_IDLE: begin
`ifdef ARB_FETCH_GUARD_EN
        take_data = bus.d_req_i && !(bus.if_req_i && run_cnt_q == RUN_W'(MAX_DATA_RUN));
        // Count only data wins that made a waiting fetch lose; anything else restarts the run.
        if (bus.if_req_i && take_data) run_cnt_d = run_cnt_q + RUN_W'(1);
        else                           run_cnt_d = '0;
`else
        take_data = bus.d_req_i;
`endif
        if (take_data) begin
          owner_d = OWN_DATA;
          we_d    = bus.d_we_i;
          addr_d  = bus.d_addr_i;
          wdata_d = bus.d_wdata_i;
          state_d = ARB_ISSUE;
        end else if (bus.if_req_i) begin
          owner_d = OWN_FETCH;
          we_d    = 1'b0;
          addr_d  = bus.if_addr_i;
          wdata_d = '0;
          state_d = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        bus.mem_en_o    = 1'b1;
        bus.mem_we_o    = we_q;
        bus.mem_addr_o  = addr_q;
        bus.mem_wdata_o = wdata_q;
        bus.d_gnt_o     = (owner_q == OWN_DATA);
        bus.if_gnt_o    = (owner_q == OWN_FETCH);
        lat_cnt_d       = LAT_W'(1);
        state_d         = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (lat_cnt_q == LAT_W'(MEM_LAT)) begin
          if (!we_q) begin
            if (owner_q == OWN_DATA) d_rdata_d  = bus.mem_rdata_i;
            else                     if_rdata_d = bus.mem_rdata_i;
          end
          lat_cnt_d = '0;
          state_d   = ARB_RESP;
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end
      ARB_RESP: begin
        d_valid        = (owner_q == OWN_DATA);
        bus.if_valid_o = (owner_q == OWN_FETCH);
        state_d        = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase

    bus.d_valid_o = d_valid;
    // Hold fetch/decode from the request cycle until the data response is returned.
    bus.stall_o   = (bus.d_req_i || (state_q != ARB_IDLE && owner_q == OWN_DATA)) && !d_valid;
  end

  assign bus.if_rdata_o = if_rdata_q;
  assign bus.d_rdata_o  = d_rdata_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ARB_IDLE;
      owner_q    <= OWN_FETCH;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      lat_cnt_q  <= '0;
`ifdef ARB_FETCH_GUARD_EN
      run_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      lat_cnt_q  <= lat_cnt_d;
`ifdef ARB_FETCH_GUARD_EN
      run_cnt_q  <= run_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table on a MEM_LAT=2 instance,
// plus fetch-guard, and MEM_LAT=1/8 latency sequences.
module tb_mem_port_arbiter;

  localparam logic [31:0] BAD = 32'hBAD0BAD0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();
  mem_port_arbiter_if bus1 ();
  mem_port_arbiter_if bus8 ();

  mem_port_arbiter #(.MEM_LAT(2)) dut  (.clk_i(clk), .rst_i(rst), .bus(bus));
  mem_port_arbiter #(.MEM_LAT(1)) dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1));
  mem_port_arbiter #(.MEM_LAT(8)) dut8 (.clk_i(clk), .rst_i(rst), .bus(bus8));

  // Memory model: fixed contents plus the most recent store.
  logic        st_vld;
  logic [31:0] st_addr, st_data;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (st_vld && a == st_addr) return st_data;
    case (a)
      32'h100: return 32'hDEADBEEF;
      32'h040: return 32'hCAFE0040;
      default: return {16'hA5A5, a[15:0]};
    endcase
  endfunction

  logic [31:0] p2 [0:1];
  logic        v2 [0:1];
  logic [31:0] p1;
  logic        v1;
  logic [31:0] p8 [0:7];
  logic        v8 [0:7];

  always @(posedge clk) begin
    if (rst) begin
      st_vld <= 1'b0; st_addr <= '0; st_data <= '0;
      v1 <= 1'b0; p1 <= '0;
      for (int i = 0; i < 2; i++) begin v2[i] <= 1'b0; p2[i] <= '0; end
      for (int i = 0; i < 8; i++) begin v8[i] <= 1'b0; p8[i] <= '0; end
    end else begin
      if (bus.mem_en_o && bus.mem_we_o) begin
        st_vld <= 1'b1; st_addr <= bus.mem_addr_o; st_data <= bus.mem_wdata_o;
      end
      v2[0] <= bus.mem_en_o && !bus.mem_we_o; p2[0] <= mem_val(bus.mem_addr_o);
      v2[1] <= v2[0];                          p2[1] <= p2[0];
      v1 <= bus1.mem_en_o;                     p1 <= mem_val(bus1.mem_addr_o);
      v8[0] <= bus8.mem_en_o;                  p8[0] <= mem_val(bus8.mem_addr_o);
      for (int i = 1; i < 8; i++) begin v8[i] <= v8[i-1]; p8[i] <= p8[i-1]; end
    end
  end

  assign bus.mem_rdata_i  = v2[1] ? p2[1] : BAD;
  assign bus1.mem_rdata_i = v1    ? p1    : BAD;
  assign bus8.mem_rdata_i = v8[7] ? p8[7] : BAD;

  // flags = {d_gnt, d_valid, if_gnt, if_valid, stall, mem_en, mem_we}
  typedef struct {
    logic        rst, d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic        if_req;
    logic [31:0] if_addr;
    logic [6:0]  flags;
    logic [31:0] e_addr, e_wdata, e_drd, e_ird;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic r, dq, dw, input logic [31:0] da, dd,
                              input logic iq, input logic [31:0] ia, input logic [6:0] fl,
                              input logic [31:0] ea, ew, edr, eir);
    vec_t v;
    v.rst = r; v.d_req = dq; v.d_we = dw; v.d_addr = da; v.d_wdata = dd;
    v.if_req = iq; v.if_addr = ia; v.flags = fl;
    v.e_addr = ea; v.e_wdata = ew; v.e_drd = edr; v.e_ird = eir;
    return v;
  endfunction

  function automatic logic [6:0] got_flags();
    return {bus.d_gnt_o, bus.d_valid_o, bus.if_gnt_o, bus.if_valid_o,
            bus.stall_o, bus.mem_en_o, bus.mem_we_o};
  endfunction

  task automatic drive(input vec_t v);
    rst = v.rst;
    bus.d_req_i = v.d_req; bus.d_we_i = v.d_we; bus.d_addr_i = v.d_addr; bus.d_wdata_i = v.d_wdata;
    bus.if_req_i = v.if_req; bus.if_addr_i = v.if_addr;
  endtask

  task automatic check_main(input string name, input vec_t v);
    logic [6:0] gf;
    gf = got_flags();
    n_vec++;
    if (gf !== v.flags || bus.mem_addr_o !== v.e_addr || bus.mem_wdata_o !== v.e_wdata ||
        bus.d_rdata_o !== v.e_drd || bus.if_rdata_o !== v.e_ird) begin
      n_err++;
      $display("FAIL %s: got flags=%b addr=%h wdata=%h drd=%h ird=%h, want flags=%b addr=%h wdata=%h drd=%h ird=%h",
               name, gf, bus.mem_addr_o, bus.mem_wdata_o, bus.d_rdata_o, bus.if_rdata_o,
               v.flags, v.e_addr, v.e_wdata, v.e_drd, v.e_ird);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  localparam logic [31:0] D = 32'hDEADBEEF, S = 32'h12345678, C = 32'hCAFE0040;

  initial begin
    vec_t z;
    bus.d_req_i = 0; bus.d_we_i = 0; bus.d_addr_i = 0; bus.d_wdata_i = 0;
    bus.if_req_i = 0; bus.if_addr_i = 0;
    bus1.d_req_i = 0; bus1.d_we_i = 0; bus1.d_addr_i = 0; bus1.d_wdata_i = 0;
    bus1.if_req_i = 0; bus1.if_addr_i = 0;
    bus8.d_req_i = 0; bus8.d_we_i = 0; bus8.d_addr_i = 0; bus8.d_wdata_i = 0;
    bus8.if_req_i = 0; bus8.if_addr_i = 0;

    // rst dq dw  d_addr  d_wdata if if_addr  flags       e_addr  e_wdata e_drd e_ird
    // lone load
    tbl.push_back(mk(0, 1, 0, 32'h100, 0, 0, 0,      7'b0000100, 0,      0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h100, 0, 0, 0,      7'b1000110, 32'h100, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,       0, 0, 0,      7'b0000100, 0,      0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,       0, 0, 0,      7'b0000100, 0,      0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,       0, 0, 0,      7'b0100000, 0,      0, D, 0));
    tbl.push_back(mk(0, 0, 0, 0,       0, 0, 0,      7'b0000000, 0,      0, D, 0));
    // store
    tbl.push_back(mk(0, 1, 1, 32'h20,  S, 0, 0,      7'b0000100, 0,      0, D, 0));
    tbl.push_back(mk(0, 1, 1, 32'h20,  S, 0, 0,      7'b1000111, 32'h20, S, D, 0));
    tbl.push_back(mk(0, 0, 0, 0,       0, 0, 0,      7'b0000100, 0,      0, D, 0));
    tbl.push_back(mk(0, 0, 0, 0,       0, 0, 0,      7'b0000100, 0,      0, D, 0));
    tbl.push_back(mk(0, 0, 0, 0,       0, 0, 0,      7'b0100000, 0,      0, D, 0));
    tbl.push_back(mk(0, 0, 0, 0,       0, 0, 0,      7'b0000000, 0,      0, D, 0));
    // simultaneous load of the stored word and fetch
    tbl.push_back(mk(0, 1, 0, 32'h20,  0, 1, 32'h40, 7'b0000100, 0,      0, D, 0));
    tbl.push_back(mk(0, 1, 0, 32'h20,  0, 1, 32'h40, 7'b1000110, 32'h20, 0, D, 0));
    tbl.push_back(mk(0, 0, 0, 0,       0, 1, 32'h40, 7'b0000100, 0,      0, D, 0));
    tbl.push_back(mk(0, 0, 0, 0,       0, 1, 32'h40, 7'b0000100, 0,      0, D, 0));
    tbl.push_back(mk(0, 0, 0, 0,       0, 1, 32'h40, 7'b0100000, 0,      0, S, 0));
    tbl.push_back(mk(0, 0, 0, 0,       0, 1, 32'h40, 7'b0000000, 0,      0, S, 0));
    tbl.push_back(mk(0, 0, 0, 0,       0, 1, 32'h40, 7'b0010010, 32'h40, 0, S, 0));
    tbl.push_back(mk(0, 0, 0, 0,       0, 0, 0,      7'b0000000, 0,      0, S, 0));
    tbl.push_back(mk(0, 0, 0, 0,       0, 0, 0,      7'b0000000, 0,      0, S, 0));
    tbl.push_back(mk(0, 0, 0, 0,       0, 0, 0,      7'b0001000, 0,      0, S, C));
    // reset in the middle of a load, then a fetch right after
    tbl.push_back(mk(0, 1, 0, 32'h100, 0, 0, 0,      7'b0000100, 0,      0, S, C));
    tbl.push_back(mk(0, 1, 0, 32'h100, 0, 0, 0,      7'b1000110, 32'h100, 0, S, C));
    tbl.push_back(mk(1, 0, 0, 0,       0, 0, 0,      7'b0000100, 0,      0, S, C));
    tbl.push_back(mk(0, 0, 0, 0,       0, 1, 32'h40, 7'b0000000, 0,      0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,       0, 1, 32'h40, 7'b0010010, 32'h40, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,       0, 0, 0,      7'b0000000, 0,      0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,       0, 0, 0,      7'b0000000, 0,      0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,       0, 0, 0,      7'b0001000, 0,      0, 0, C));
    tbl.push_back(mk(0, 0, 0, 0,       0, 0, 0,      7'b0000000, 0,      0, 0, C));

    // reset state
    rst = 1'b1;
    repeat (3) next_cycle();
    z = mk(1, 0, 0, 0, 0, 0, 0, 7'b0, 0, 0, 0, 0);
    @(negedge clk);
    check_main("reset", z);
    n_vec++;
    if ({bus1.if_gnt_o, bus1.if_valid_o, bus1.mem_en_o, bus1.if_rdata_o,
         bus8.if_gnt_o, bus8.if_valid_o, bus8.mem_en_o, bus8.if_rdata_o} !== '0) begin
      n_err++;
      $display("FAIL reset_lat: lat1/lat8 outputs not all zero after reset");
    end
    next_cycle();

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      @(negedge clk);
      check_main($sformatf("vec%0d", i), tbl[i]);
      next_cycle();
    end
    rst = 1'b0;

    // Both requesters held high: record who wins each arbitration.
    bus.d_req_i = 1; bus.d_we_i = 0; bus.d_addr_i = 32'h100; bus.if_req_i = 1; bus.if_addr_i = 32'h40;
    for (int k = 0; k < 6; k++) begin
      logic found, got_f, exp_f;
      found = 1'b0; got_f = 1'b0;
`ifdef ARB_FETCH_GUARD_EN
      exp_f = (k == 4);
`else
      exp_f = 1'b0;
`endif
      for (int c = 0; c < 10 && !found; c++) begin
        @(negedge clk);
        if (bus.d_gnt_o || bus.if_gnt_o) begin found = 1'b1; got_f = bus.if_gnt_o; end
        next_cycle();
      end
      n_vec++;
      if (!found || got_f !== exp_f) begin
        n_err++;
        $display("FAIL guard_grant%0d: found=%0d fetch=%0d, want found=1 fetch=%0d", k, found, got_f, exp_f);
      end
    end
    bus.d_req_i = 0; bus.if_req_i = 0;
    repeat (8) next_cycle();

    // Lone fetches on the MEM_LAT=1 and MEM_LAT=8 instances.
    bus1.if_req_i = 1; bus1.if_addr_i = 32'h40;
    bus8.if_req_i = 1; bus8.if_addr_i = 32'h40;
    for (int k = 0; k < 12; k++) begin
      if (k == 2) begin bus1.if_req_i = 0; bus8.if_req_i = 0; end
      @(negedge clk);
      n_vec++;
      if ({bus1.if_gnt_o, bus1.if_valid_o, bus1.if_rdata_o} !==
          {k == 1, k == 3, (k >= 3) ? C : 32'h0}) begin
        n_err++;
        $display("FAIL lat1_c%0d: gnt=%0d valid=%0d rdata=%h", k, bus1.if_gnt_o, bus1.if_valid_o, bus1.if_rdata_o);
      end
      n_vec++;
      if ({bus8.if_gnt_o, bus8.if_valid_o, bus8.if_rdata_o} !==
          {k == 1, k == 10, (k >= 10) ? C : 32'h0}) begin
        n_err++;
        $display("FAIL lat8_c%0d: gnt=%0d valid=%0d rdata=%h", k, bus8.if_gnt_o, bus8.if_valid_o, bus8.if_rdata_o);
      end
      next_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
